// File: rtl/pmod_als_resp_pkg.sv
// Shared state encoding, default geometry and pin idle levels for the PMOD ALS
// SPI responder.
package pmod_als_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } resp_state_t;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_LEAD_ZEROS  = 3;
    localparam int DEF_FRAME_BITS  = 16;
    localparam int DEF_SYNC_STAGES = 2;

    localparam logic CS_IDLE  = 1'b1;
    localparam logic SCK_IDLE = 1'b1;

endpackage

// File: rtl/spi_in_sync.sv
// N-stage synchronizer for an asynchronous SPI pin, with an edge-detect flop
// producing single-cycle rise/fall pulses. Flops reset to the pin's idle level.
module spi_in_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    if (STAGES < 2) begin : g_bad_stages
        $error("spi_in_sync: STAGES must be at least 2");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/pmod_als_spi_responder.sv
// SPI mode-3 slave modelling the PMOD ALS ADC: frames a host-written sample as
// leading zeros, data MSB first, trailing zeros. Define PMOD_ALS_RESP_ABORT_CNT_EN
// to add a saturating abort_count output.
module pmod_als_spi_responder
    import pmod_als_resp_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int LEAD_ZEROS  = DEF_LEAD_ZEROS,
    parameter int FRAME_BITS  = DEF_FRAME_BITS,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_we,
    input  logic              cs,
    input  logic              sck,
    output logic              sdo,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_abort,
    output logic [15:0]       frames
`ifdef PMOD_ALS_RESP_ABORT_CNT_EN
    ,
    output logic [7:0]        abort_count
`endif
);

    localparam int TRAIL_ZEROS = FRAME_BITS - LEAD_ZEROS - DATA_W;
    localparam int CNT_W       = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_RISE = CNT_W'(FRAME_BITS - 1);

    if (TRAIL_ZEROS < 0) begin : g_bad_frame
        $error("pmod_als_spi_responder: FRAME_BITS too small for LEAD_ZEROS + DATA_W");
    end

    resp_state_t           state_q, state_n;
    logic [FRAME_BITS-1:0] sh_q, sh_n, frame_word;
    logic [CNT_W-1:0]      cnt_q, cnt_n;
    logic [DATA_W-1:0]     hold_q, load_val;
    logic [SYNC_STAGES:0]  settle_q;
    logic                  armed_q;
    logic                  sdo_n, done_n, abort_n;
    logic [15:0]           frames_n;
    logic                  cs_lvl, cs_rise, cs_fall;
    logic                  sck_lvl_unused, sck_rise, sck_fall;

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CS_IDLE)) u_cs_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (cs),
        .level (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SCK_IDLE)) u_sck_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (sck),
        .level (sck_lvl_unused),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    // A write coinciding with the cs-fall is framed directly (bypass).
    always_comb begin
        load_val               = sample_we ? sample : hold_q;
        frame_word             = '0;
        frame_word[DATA_W-1:0] = load_val;
        frame_word             = frame_word << TRAIL_ZEROS;
    end

    always_comb begin
        state_n  = state_q;
        sh_n     = sh_q;
        cnt_n    = cnt_q;
        sdo_n    = sdo;
        done_n   = 1'b0;
        abort_n  = 1'b0;
        frames_n = frames;
        case (state_q)
            ST_IDLE: begin
                sdo_n = 1'b0;
                if (cs_fall && armed_q) begin
                    sh_n    = frame_word;
                    sdo_n   = frame_word[FRAME_BITS-1];
                    cnt_n   = '0;
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    abort_n = 1'b1;
                    sdo_n   = 1'b0;
                    state_n = ST_IDLE;
                end else if (!cs_lvl) begin
                    if (sck_rise) begin
                        cnt_n = cnt_q + 1'b1;
                        if (cnt_q == LAST_RISE) begin
                            done_n   = 1'b1;
                            frames_n = frames + 16'd1;
                            sdo_n    = 1'b0;
                            state_n  = ST_DONE;
                        end
                    end else if (sck_fall && cnt_q != '0) begin
                        // The opening mode-3 fall carries no shift; MSB is already out.
                        sh_n  = sh_q << 1;
                        sdo_n = sh_n[FRAME_BITS-1];
                    end
                end
            end
            ST_DONE: begin
                sdo_n = 1'b0;
                if (cs_rise) state_n = ST_IDLE;
            end
            default: begin
                sdo_n   = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            sdo         <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            frames      <= '0;
            settle_q    <= '0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_n;
            sh_q        <= sh_n;
            cnt_q       <= cnt_n;
            sdo         <= sdo_n;
            frame_done  <= done_n;
            frame_abort <= abort_n;
            frames      <= frames_n;
            if (sample_we) hold_q <= sample;
            // cs must be seen high on the real pin after reset before a fall counts.
            settle_q <= {settle_q[SYNC_STAGES-1:0], 1'b1};
            if (settle_q[SYNC_STAGES] && cs_lvl) armed_q <= 1'b1;
        end
    end

    assign busy = (state_q == ST_SHIFT);

`ifdef PMOD_ALS_RESP_ABORT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            abort_count <= '0;
        end else if (abort_n && abort_count != 8'hFF) begin
            abort_count <= abort_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pmod_als_spi_responder.sv
// Bench for pmod_als_spi_responder: a mode-3 master drives cs/sck and collects
// sdo, compared against frames built from the sample value arithmetically.
module tb_pmod_als_spi_responder;

    localparam int DW    = 8;
    localparam int LEAD  = 3;
    localparam int FB    = 16;
    localparam int SYNC  = 2;
    localparam int HALF  = 10;
    localparam int TRAIL = FB - LEAD - DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] sample = '0;
    logic          sample_we = 1'b0;
    logic          cs = 1'b1;
    logic          sck = 1'b1;
    logic          sdo, busy, frame_done, frame_abort;
    logic [15:0]   frames;
`ifdef PMOD_ALS_RESP_ABORT_CNT_EN
    logic [7:0]    abort_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    int n_abort  = 0;
    logic [DW-1:0] model_hold = '0;
    int exp_frames = 0;

    pmod_als_spi_responder #(
        .DATA_W(DW), .LEAD_ZEROS(LEAD), .FRAME_BITS(FB), .SYNC_STAGES(SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample      (sample),
        .sample_we   (sample_we),
        .cs          (cs),
        .sck         (sck),
        .sdo         (sdo),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .frames      (frames)
`ifdef PMOD_ALS_RESP_ABORT_CNT_EN
        ,
        .abort_count (abort_count)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done)  n_done++;
        if (frame_abort) n_abort++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] frame_of(input logic [DW-1:0] s);
        return 16'(int'(s) * (1 << TRAIL));
    endfunction

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_sample(input logic [DW-1:0] v);
        sample = v;
        sample_we = 1'b1;
        clk_wait(1);
        sample_we = 1'b0;
        model_hold = v;
    endtask

    task automatic cs_low(input bit bypass, input logic [DW-1:0] bval, output logic [15:0] exp);
        cs = 1'b0;
        if (bypass) begin
            clk_wait(SYNC);
            write_sample(bval);
            clk_wait(HALF - SYNC - 1);
        end else begin
            clk_wait(HALF);
        end
        exp = frame_of(model_hold);
    endtask

    task automatic cs_high();
        cs = 1'b1;
        clk_wait(2 * HALF);
    endtask

    task automatic sck_cycles(input int n, input bit midwrite, output logic [15:0] rx, output logic extra);
        rx = '0;
        extra = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (midwrite && i == n / 2) write_sample(DW'($urandom));
            sck = 1'b0;
            clk_wait(HALF);
            if (i < FB) rx = {rx[14:0], sdo};
            else        extra = extra | sdo;
            sck = 1'b1;
            clk_wait(HALF);
        end
    endtask

    initial begin
        logic [15:0] exp, rx;
        logic        extra;
        int          d0, a0;
        bit          byp;
        logic [DW-1:0] v;

        clk_wait(3);
        chk("rst_sdo", 32'(sdo), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_abort", 32'(frame_abort), 0);
        chk("rst_frames", 32'(frames), 0);
        rst = 1'b0;
        clk_wait(SYNC + 4);

        // Basic frame
        write_sample(8'hA5);
        d0 = n_done;
        cs_low(1'b0, '0, exp);
        chk("basic_busy", 32'(busy), 1);
        sck_cycles(FB, 1'b0, rx, extra);
        cs_high();
        exp_frames++;
        chk("basic_word", 32'(rx), 32'h14A0);
        chk("basic_model", 32'(rx), 32'(exp));
        chk("basic_done", 32'(n_done - d0), 1);
        chk("basic_frames", 32'(frames), 32'(exp_frames));
        chk("basic_busy_after", 32'(busy), 0);

        // Write coinciding with cs-fall detection is framed
        write_sample(8'hFF);
        cs_low(1'b1, 8'h3C, exp);
        sck_cycles(FB, 1'b0, rx, extra);
        cs_high();
        exp_frames++;
        chk("latch_word", 32'(rx), 32'h0780);

        // Randomized frames, with mid-frame writes and bypass writes
        for (int k = 0; k < 6; k++) begin
            byp = 1'($urandom);
            v = DW'($urandom);
            if (!byp) write_sample(DW'($urandom));
            cs_low(byp, v, exp);
            sck_cycles(FB, 1'($urandom), rx, extra);
            cs_high();
            exp_frames++;
            chk("rand_word", 32'(rx), 32'(exp));
            chk("rand_frames", 32'(frames), 32'(exp_frames));
        end

        // Abort after 7 rising edges
        d0 = n_done;
        a0 = n_abort;
        write_sample(8'h5A);
        cs_low(1'b0, '0, exp);
        sck_cycles(7, 1'b0, rx, extra);
        cs_high();
        chk("abort_pulse", 32'(n_abort - a0), 1);
        chk("abort_no_done", 32'(n_done - d0), 0);
        chk("abort_frames", 32'(frames), 32'(exp_frames));
        chk("abort_sdo", 32'(sdo), 0);
        chk("abort_busy", 32'(busy), 0);
`ifdef PMOD_ALS_RESP_ABORT_CNT_EN
        chk("abort_count_1", 32'(abort_count), 1);
`endif
        cs_low(1'b0, '0, exp);
        sck_cycles(FB, 1'b0, rx, extra);
        cs_high();
        exp_frames++;
        chk("post_abort_word", 32'(rx), 32'(frame_of(8'h5A)));
`ifdef PMOD_ALS_RESP_ABORT_CNT_EN
        for (int k = 0; k < 299; k++) begin
            cs_low(1'b0, '0, exp);
            sck_cycles(1, 1'b0, rx, extra);
            cs_high();
        end
        chk("abort_count_sat", 32'(abort_count), 32'hFF);
        chk("abort_sat_pulses", 32'(n_abort - a0), 300);
`endif

        // Overclock: extra sck cycles after the frame
        d0 = n_done;
        write_sample(DW'($urandom));
        cs_low(1'b0, '0, exp);
        sck_cycles(FB + 20, 1'b0, rx, extra);
        chk("over_sdo_busy", 32'(busy), 0);
        cs_high();
        exp_frames++;
        chk("over_word", 32'(rx), 32'(exp));
        chk("over_extra_zero", 32'(extra), 0);
        chk("over_done", 32'(n_done - d0), 1);
        chk("over_frames", 32'(frames), 32'(exp_frames));

        // Reset mid-frame with cs held low
        write_sample(8'hC3);
        cs_low(1'b0, '0, exp);
        sck_cycles(5, 1'b0, rx, extra);
        rst = 1'b1;
        clk_wait(1);
        rst = 1'b0;
        model_hold = '0;
        exp_frames = 0;
        d0 = n_done;
        a0 = n_abort;
        sck_cycles(FB - 5, 1'b0, rx, extra);
        chk("rstmid_sdo", 32'(rx), 0);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_frames", 32'(frames), 0);
        cs_high();
        chk("rstmid_no_pulse", 32'(n_done - d0 + n_abort - a0), 0);
        write_sample(8'h96);
        cs_low(1'b0, '0, exp);
        sck_cycles(FB, 1'b0, rx, extra);
        cs_high();
        exp_frames++;
        chk("rstmid_next_word", 32'(rx), 32'(frame_of(8'h96)));
        chk("rstmid_next_frames", 32'(frames), 32'(exp_frames));

        // Frame counter wrap
        @(posedge clk);
        #1 force dut.frames = 16'hFFFF;
        clk_wait(1);
        release dut.frames;
        clk_wait(1);
        cs_low(1'b0, '0, exp);
        sck_cycles(FB, 1'b0, rx, extra);
        cs_high();
        chk("wrap_frames", 32'(frames), 0);
        chk("wrap_word", 32'(rx), 32'(exp));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pmod_als_spi_responder.md
Name: pmod_als_spi_responder

Overview:
- SPI slave that models the PMOD ALS light-sensor ADC. It is the transmitting end of the light-sensor link whose master-side receiver sits in the GPIO block.
- Drives SDO in response to the master's CS/SCK, using SPI mode 3 (CPOL=1, CPHA=1).
- A host-written sample is framed as leading zeros, then the data bits MSB first, then trailing zeros.
- Used for on-board loopback and simulation of the GPIO light-sensor path without real hardware.

Parameters:
- DATA_W, 8, sample width.
- LEAD_ZEROS, 3, zero bits sent before the data.
- FRAME_BITS, 16, total bits per frame. Trailing zeros = FRAME_BITS-LEAD_ZEROS-DATA_W, which must be >=0 (elaboration error otherwise).
- SYNC_STAGES, 2, synchronizer depth for cs/sck (>=2).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- sample  in  DATA_W  value to transmit.
- sample_we  in  1  load sample into the holding register.
- cs  in  1  chip select from master, active-low, asynchronous to clk.
- sck  in  1  SPI clock from master, idles high, asynchronous to clk.
- sdo  out  1  serial data to master.
- busy  out  1  high while a frame is in progress (state SHIFT).
- frame_done  out  1  one-cycle pulse after the FRAME_BITS-th sampled bit.
- frame_abort  out  1  one-cycle pulse when cs rises before frame completion.
- frames  out  16  count of completed frames; wraps 0xFFFF->0.

Behaviour:
- Reset values:
  - All outputs are 0.
  - Holding register = 0, shift register = 0, bit counter = 0, state IDLE.
  - Synchronizer flops and previous-value flops reset to 1 (the idle level of cs and sck).
- Input synchronization:
  - cs and sck each pass through SYNC_STAGES flops, plus one flop for edge detection.
  - An edge is seen SYNC_STAGES+1 clk after the pin toggles.
  - sdo changes 1 clk after the detected edge.
  - Requirement: clk period*(SYNC_STAGES+2) < SCK half period.
- Holding register:
  - sample_we loads it in any state.
  - A write during a frame does not affect the frame in flight.
  - If sample_we and cs-fall are detected in the same cycle, the new sample is framed (bypass).
- States:
  - IDLE:
    - sdo=0.
    - On cs-fall: shift register <= {LEAD_ZEROS zeros, hold, trailing zeros}; sdo <= its MSB; rise_cnt <= 0; go to SHIFT.
  - SHIFT:
    - sck-rise (cs low): rise_cnt++. When rise_cnt reaches FRAME_BITS: pulse frame_done, frames++, go to DONE.
    - sck-fall (cs low): shift only if rise_cnt>=1, then sdo <= next bit. A fall with rise_cnt==0 (the first mode-3 edge) does not shift.
    - cs-rise: pulse frame_abort, sdo <= 0, go to IDLE.
  - DONE:
    - sdo=0 regardless of further sck edges.
    - cs-rise returns to IDLE with no pulse.
- Simultaneous edges: cs-rise takes priority over sck edges in the same cycle.
- Reset mid-frame: returns to IDLE. Because the synchronizers reset to 1, a new frame starts only after cs is seen high and then low again.
- If cs is held low through reset, it is not treated as a frame start.
- Extra sck edges while in IDLE are ignored.

Optional Feature:
- Macro: PMOD_ALS_RESP_ABORT_CNT_EN.
- Defined:
  - Adds output port abort_count [7:0].
  - Increments on every frame_abort and saturates at 0xFF.
  - Cleared by rst.
- Undefined:
  - Port and counter are absent.
  - frame_abort pulses unchanged.

Decomposition:
- Package pmod_als_resp_pkg holds:
  - the state encoding (IDLE, SHIFT, DONE);
  - default values for DATA_W, LEAD_ZEROS, FRAME_BITS, SYNC_STAGES;
  - the idle levels for cs and sck.
- One sub-module, spi_in_sync: an N-stage synchronizer plus rise/fall pulse outputs with a reset level parameter. It is instantiated once for cs and once for sck.
- Framing, counting and the FSM stay in the top module.

Test Plan:
- Basic frame:
  - Stimulus: write sample 0xA5, then a mode-3 master with 16 SCK cycles at 10 clk per half-bit.
  - Response: master samples 0x14A0 (000_10100101_00000); one frame_done pulse; frames=1; busy is low afterwards.
- Data latching:
  - Stimulus: sample_we 0x3C in the same clk that cs-fall is detected, after a prior hold of 0xFF.
  - Response: frame carries 0x3C, giving 0x0780.
- Abort:
  - Stimulus: cs rises after 7 SCK rising edges.
  - Response: one frame_abort pulse; no frame_done; frames unchanged; sdo=0; the next full frame is correct.
  - With PMOD_ALS_RESP_ABORT_CNT_EN: abort_count=1. Aborting 300 times saturates it at 0xFF.
- Overclock:
  - Stimulus: 20 extra SCK cycles after the 16th with cs still low.
  - Response: sdo stays 0; frames increments exactly once.
- Reset mid-frame:
  - Stimulus: assert rst for 1 clk after bit 5 while cs stays low, then complete the SCK cycles.
  - Response: sdo=0, no pulses, frames=0. After cs goes high then low, the next frame is correct.
- Counter wrap:
  - Stimulus: force 65536 completed frames (or preload via bench hierarchy to 0xFFFF and run one frame).
  - Response: frames reads 0x0000.
